// File: rtl/deserializador_n.sv
// Serial-to-parallel converter with a shift register and a double-buffered holding register.
// Stalls (FULL) when a word completes while the previous one is still unacknowledged.
module deserializador_n #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                       clock_100KHz,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       ack_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_ready,
    output logic                       status_out,
    output logic                       overrun_out,
    output logic [$clog2(WIDTH+1)-1:0] bit_count_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {StReceiving, StFull} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [IW-1:0]    pos;
    logic             last_bit;

    always_comb begin
        if (MSB_FIRST != 0) begin
            pos = IW'(WIDTH - 1) - IW'(bit_count_out);
        end else begin
            pos = IW'(bit_count_out);
        end
        shift_next      = shift_q;
        shift_next[pos] = data_in;
        last_bit        = (bit_count_out == CW'(WIDTH - 1));
    end

    assign status_out = (state_q == StReceiving);

    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            state_q       <= StReceiving;
            shift_q       <= '0;
            data_out      <= '0;
            data_ready    <= 1'b0;
            overrun_out   <= 1'b0;
            bit_count_out <= '0;
        end else begin
            unique case (state_q)
                StReceiving: begin
                    if (write_in && last_bit) begin
                        if (!data_ready || ack_in) begin
                            data_out      <= shift_next;
                            data_ready    <= 1'b1;
                            bit_count_out <= '0;
                            shift_q       <= '0;
                        end else begin
                            // Holding register busy: park the word and stall input.
                            shift_q       <= shift_next;
                            bit_count_out <= CW'(WIDTH);
                            state_q       <= StFull;
                        end
                    end else begin
                        if (write_in) begin
                            shift_q       <= shift_next;
                            bit_count_out <= bit_count_out + CW'(1);
                        end
                        if (ack_in && data_ready) begin
                            data_ready <= 1'b0;
                            data_out   <= '0;
                        end
                    end
                end
                StFull: begin
                    if (write_in) begin
                        overrun_out <= 1'b1;
                    end
                    if (ack_in) begin
                        data_out      <= shift_q;
                        shift_q       <= '0;
                        bit_count_out <= '0;
                        state_q       <= StReceiving;
                    end
                end
                default: state_q <= StReceiving;
            endcase
        end
    end

endmodule

// File: tb/tb_deserializador_n.sv
// Bench for deserializador_n: LSB-first and MSB-first instances driven in parallel,
// checked against a queue-based model of received bits.
module tb_deserializador_n;

    logic       clk;
    logic       rst;
    logic       din;
    logic       wr;
    logic       ack;

    logic [7:0] l_data, m_data;
    logic       l_ready, m_ready, l_status, m_status, l_ovr, m_ovr;
    logic [3:0] l_cnt, m_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: bits received for the current word, plus holding-register contents.
    bit         q_bits[$];
    logic [7:0] e_hold_l, e_hold_m;
    logic       e_ready, e_full, e_ovr;

    deserializador_n #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clock_100KHz (clk),
        .reset        (rst),
        .data_in      (din),
        .write_in     (wr),
        .ack_in       (ack),
        .data_out     (l_data),
        .data_ready   (l_ready),
        .status_out   (l_status),
        .overrun_out  (l_ovr),
        .bit_count_out(l_cnt)
    );

    deserializador_n #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clock_100KHz (clk),
        .reset        (rst),
        .data_in      (din),
        .write_in     (wr),
        .ack_in       (ack),
        .data_out     (m_data),
        .data_ready   (m_ready),
        .status_out   (m_status),
        .overrun_out  (m_ovr),
        .bit_count_out(m_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pack(input bit msb);
        logic [7:0] w = 8'h00;
        for (int i = 0; i < q_bits.size(); i++) begin
            if (q_bits[i]) w = w | (8'h01 << (msb ? 7 - i : i));
        end
        return w;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    task automatic model_edge();
        if (rst) begin
            q_bits.delete();
            e_hold_l = 8'h00; e_hold_m = 8'h00;
            e_ready = 1'b0; e_full = 1'b0; e_ovr = 1'b0;
        end else if (e_full) begin
            if (wr) e_ovr = 1'b1;
            if (ack) begin
                e_hold_l = pack(1'b0); e_hold_m = pack(1'b1);
                q_bits.delete();
                e_full = 1'b0;
            end
        end else begin
            bit done = 1'b0;
            if (wr) begin
                q_bits.push_back(din);
                if (q_bits.size() == 8) begin
                    done = 1'b1;
                    if (!e_ready || ack) begin
                        e_hold_l = pack(1'b0); e_hold_m = pack(1'b1);
                        e_ready = 1'b1;
                        q_bits.delete();
                    end else begin
                        e_full = 1'b1;
                    end
                end
            end
            if (!done && ack && e_ready) begin
                e_ready = 1'b0;
                e_hold_l = 8'h00; e_hold_m = 8'h00;
            end
        end
    endtask

    // Drive inputs on the falling edge, update the model at the rising edge, settle 1ns.
    task automatic step(input logic r, input logic w, input logic d, input logic a);
        @(negedge clk);
        rst = r; wr = w; din = d; ack = a;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_4d();
        logic [7:0] seq = 8'b0100_1101;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, seq[i], 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (l_data !== 8'h00 || l_ready !== 1'b0 || l_status !== 1'b1 || l_ovr !== 1'b0 ||
            l_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_lsb: got data=%h rdy=%b st=%b ovr=%b cnt=%0d expected 00 0 1 0 0",
                     l_data, l_ready, l_status, l_ovr, l_cnt);
        end
        checks++;
        if (m_data !== 8'h00 || m_ready !== 1'b0 || m_status !== 1'b1 || m_ovr !== 1'b0 ||
            m_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_msb: got data=%h rdy=%b st=%b ovr=%b cnt=%0d expected 00 0 1 0 0",
                     m_data, m_ready, m_status, m_ovr, m_cnt);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_word_order();
        logic [7:0] seq = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, seq[i], 1'b0);
            if (i == 2) begin
                checks++;
                if (l_cnt !== 4'd3 || l_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL partial_count: got cnt=%0d rdy=%b expected 3 0", l_cnt, l_ready);
                end
            end
        end
        checks++;
        if (l_data !== 8'h4D || l_ready !== 1'b1 || l_cnt !== 4'd0) begin
            failures++;
            $display("FAIL word_lsb: got data=%h rdy=%b cnt=%0d expected 4d 1 0",
                     l_data, l_ready, l_cnt);
        end
        checks++;
        if (m_data !== 8'hB2 || m_ready !== 1'b1 || m_cnt !== 4'd0) begin
            failures++;
            $display("FAIL word_msb: got data=%h rdy=%b cnt=%0d expected b2 1 0",
                     m_data, m_ready, m_cnt);
        end
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (i < 7) begin
                checks++;
                if (l_status !== 1'b1) begin
                    failures++;
                    $display("FAIL early_full: bit %0d got status=%b expected 1", i, l_status);
                end
            end
        end
        checks++;
        if (l_status !== 1'b0 || m_status !== 1'b0 || l_data !== 8'h4D || l_cnt !== 4'd8) begin
            failures++;
            $display("FAIL enter_full: got st=%b/%b data=%h cnt=%0d expected 0/0 4d 8",
                     l_status, m_status, l_data, l_cnt);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (l_ovr !== 1'b1 || m_ovr !== 1'b1 || l_data !== 8'h4D || l_status !== 1'b0) begin
            failures++;
            $display("FAIL overrun: got ovr=%b/%b data=%h st=%b expected 1/1 4d 0",
                     l_ovr, m_ovr, l_data, l_status);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (l_data !== 8'hFF || m_data !== 8'hFF || l_ready !== 1'b1 || l_status !== 1'b1 ||
            l_cnt !== 4'd0 || l_ovr !== 1'b1) begin
            failures++;
            $display("FAIL full_ack: got data=%h/%h rdy=%b st=%b cnt=%0d ovr=%b expected ff/ff 1 1 0 1",
                     l_data, m_data, l_ready, l_status, l_cnt, l_ovr);
        end
    endtask

    task automatic test_ack_on_complete();
        logic [7:0] w = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, w[i], (i == 7));
            checks++;
            if (l_status !== 1'b1 || m_status !== 1'b1) begin
                failures++;
                $display("FAIL ack_same_edge_status: bit %0d got st=%b/%b expected 1/1",
                         i, l_status, m_status);
            end
        end
        checks++;
        if (l_data !== w || m_data !== rev8(w) || l_ready !== 1'b1 || l_cnt !== 4'd0) begin
            failures++;
            $display("FAIL ack_same_edge_data: got %h/%h rdy=%b cnt=%0d expected %h/%h 1 0",
                     l_data, m_data, l_ready, l_cnt, w, rev8(w));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (l_ready !== 1'b0 || l_data !== 8'h00 || m_data !== 8'h00) begin
            failures++;
            $display("FAIL ack_clear: got rdy=%b data=%h/%h expected 0 00/00",
                     l_ready, l_data, m_data);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (l_ready !== 1'b0 || l_status !== 1'b1) begin
            failures++;
            $display("FAIL ack_idle: got rdy=%b st=%b expected 0 1", l_ready, l_status);
        end
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (l_cnt !== 4'd0 || l_ready !== 1'b0 || l_status !== 1'b1 || l_ovr !== 1'b0) begin
            failures++;
            $display("FAIL reset_midword: got cnt=%0d rdy=%b st=%b ovr=%b expected 0 0 1 0",
                     l_cnt, l_ready, l_status, l_ovr);
        end
        send_4d();
        checks++;
        if (l_data !== 8'h4D || m_data !== 8'hB2 || l_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_word: got %h/%h rdy=%b expected 4d/b2 1",
                     l_data, m_data, l_ready);
        end
    endtask

    task automatic test_random();
        logic [3:0] e_cnt;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 1'($urandom), ($urandom_range(0, 9) < 2));
            e_cnt = 4'(q_bits.size());
            checks++;
            if (l_data !== e_hold_l || m_data !== e_hold_m) begin
                failures++;
                $display("FAIL rand_data: cycle %0d got %h/%h expected %h/%h",
                         n, l_data, m_data, e_hold_l, e_hold_m);
            end
            checks++;
            if (l_ready !== e_ready || m_ready !== e_ready || l_status !== !e_full ||
                m_status !== !e_full) begin
                failures++;
                $display("FAIL rand_flags: cycle %0d got rdy=%b/%b st=%b/%b expected rdy=%b st=%b",
                         n, l_ready, m_ready, l_status, m_status, e_ready, !e_full);
            end
            checks++;
            if (l_ovr !== e_ovr || m_ovr !== e_ovr || l_cnt !== e_cnt || m_cnt !== e_cnt) begin
                failures++;
                $display("FAIL rand_count: cycle %0d got ovr=%b/%b cnt=%0d/%0d expected %b %0d",
                         n, l_ovr, m_ovr, l_cnt, m_cnt, e_ovr, e_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; din = 1'b0; ack = 1'b0;
        q_bits.delete();
        e_hold_l = 8'h00; e_hold_m = 8'h00;
        e_ready = 1'b0; e_full = 1'b0; e_ovr = 1'b0;
        test_reset();
        test_word_order();
        test_full_overrun();
        test_ack_on_complete();
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deserializador_n.md
DESERIALIZADOR_N -- requirements
Module: deserializador_n

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 means the first received bit goes to data_out[0]; 1 means it goes to data_out[WIDTH-1].
REQ-003 Port clock_100KHz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port data_in, input, 1 bit: serial data bit.
REQ-006 Port write_in, input, 1 bit: data_in is valid this cycle.
REQ-007 Port ack_in, input, 1 bit: consumer has taken data_out.
REQ-008 Port data_out, output, WIDTH bits: holding register with the completed word.
REQ-009 Port data_ready, output, 1 bit: data_out holds an unacknowledged word.
REQ-010 Port status_out, output, 1 bit: the block accepts a bit this cycle.
REQ-011 Port overrun_out, output, 1 bit: sticky flag, a bit was offered while status_out=0.
REQ-012 Port bit_count_out, output, $clog2(WIDTH+1) bits: bits accumulated in the current partial word.

Function
REQ-013 Two registers: a shift register that accumulates bits, and the data_out holding register (double buffering).
REQ-014 FSM has two states: RECEIVING (status_out=1) and FULL (status_out=0); status_out is registered and decoded from the state only.
REQ-015 A bit is accepted on an edge where write_in=1 and status_out=1. It is placed at the position given by bit_count_out and MSB_FIRST, and bit_count_out increments.
REQ-016 write_in=0 leaves the shift register and bit_count_out unchanged; gaps between bits are legal.
REQ-017 On acceptance of the WIDTH-th bit with data_ready=0, or with data_ready=1 and ack_in=1 on the same edge:
- the completed word loads data_out on that edge;
- data_ready becomes 1;
- bit_count_out becomes 0;
- the state stays RECEIVING.
REQ-018 On acceptance of the WIDTH-th bit with data_ready=1 and ack_in=0:
- the word stays in the shift register;
- bit_count_out becomes WIDTH;
- the state becomes FULL.
REQ-019 In FULL with ack_in=1:
- the shift register word moves to data_out;
- data_ready stays 1;
- bit_count_out becomes 0;
- the state becomes RECEIVING, so status_out=1 from the next cycle.
REQ-020 In FULL with ack_in=0: all registers hold.
REQ-021 In RECEIVING with ack_in=1, data_ready=1 and no word completing on that edge: data_ready becomes 0 and data_out becomes 0 on that edge.
REQ-022 ack_in while data_ready=0 is ignored.
REQ-023 write_in=1 while status_out=0 sets overrun_out=1, drops the bit, and leaves all data registers unchanged. overrun_out is cleared only by reset.
REQ-024 Latency: data_ready and data_out update on the same edge that accepts the final bit. A word is visible 1 cycle after the final bit is presented.
REQ-025 Throughput: one bit per cycle sustained when the consumer acks each word within WIDTH cycles.

Reset
REQ-026 When reset=1 at a rising edge, the block enters RECEIVING with:
- data_out=0, data_ready=0;
- status_out=1, overrun_out=0;
- bit_count_out=0;
- shift register cleared.
REQ-027 Reset has priority over write_in and ack_in on the same edge.
REQ-028 Reset mid-word discards any partial word.
REQ-029 Reset in FULL discards both the buffered word and the holding word.

Verification
REQ-030 WIDTH=8, MSB_FIRST=0; bits 1,0,1,1,0,0,1,0 on consecutive cycles with write_in=1 -> data_out=8'h4D and data_ready=1 after the 8th edge; bit_count_out=0.
REQ-031 WIDTH=8, MSB_FIRST=1; same bit sequence -> data_out=8'hB2, data_ready=1.
REQ-032 After the word 8'h4D, with no ack, send 8 bits of 1 -> status_out=0 after the 16th bit and data_out stays 8'h4D. Then pulse ack_in -> data_out=8'hFF, data_ready=1, status_out=1 on the next cycle.
REQ-033 In FULL, assert write_in=1 with data_in=0 for 1 cycle -> overrun_out=1 and stays 1. After ack, data_out=8'hFF (the dropped bit has no effect).
REQ-034 Assert ack_in on the same edge as the 8th bit of a second word while data_ready=1 -> data_out takes the new word, data_ready stays 1, and the state never enters FULL (status_out stays 1).
REQ-035 Send 3 bits, then assert reset for 1 cycle -> bit_count_out=0, data_ready=0, status_out=1. The next 8 bits 1,0,1,1,0,0,1,0 -> data_out=8'h4D.
